row_scan_controller: RTL and testbench

ROW_SCAN_CONTROLLER -- requirements
Module: row_scan_controller

---
 rtl/row_scan_controller.sv | 151 +++++++++++++++
 tb/tb_row_scan_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/row_scan_controller.sv
// Row-scan controller for an 8x8 RGB matrix: BLANK -> LOAD -> DRIVE per row, feeding a PWM stage.
// Optional macro DOUBLE_BUFFER_EN adds a back bank swapped at end of frame on swap_req.
module row_scan_controller #(
    parameter int DWELL_PERIODS = 4,
    parameter int BLANK_CYCLES  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [5:0]  wr_addr,
    input  logic [23:0] wr_data,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic [23:0] ocr1,
    output logic [23:0] ocr2,
    output logic [23:0] ocr3,
    output logic [23:0] ocr4,
    output logic [23:0] ocr5,
    output logic [23:0] ocr6,
    output logic [23:0] ocr7,
    output logic [23:0] ocr8,
    output logic        en,
    output logic [7:0]  row_n,
    output logic        frame_start
);

    localparam int DWELL_CLKS = DWELL_PERIODS * 256;
    localparam int DW         = $clog2(DWELL_CLKS);
`ifdef DOUBLE_BUFFER_EN
    localparam int BANKS = 2;
    localparam int AW    = 7;
`else
    localparam int BANKS = 1;
    localparam int AW    = 6;
`endif
    localparam int WORDS = 64 * BANKS;

    typedef enum logic [1:0] {ST_BLANK, ST_LOAD, ST_DRIVE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    blank_q, blank_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [2:0]    row_q, row_d;
    logic [23:0]   ocr_q [8];
    logic [23:0]   ocr_d [8];
    logic [23:0]   mem_q [WORDS];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_base;
    logic          drive_done;

`ifdef DOUBLE_BUFFER_EN
    logic disp_q, pend_q, swap_fire;

    // Bank exchange only at the boundary after row 7, so a frame never mixes banks.
    assign swap_fire = drive_done && (row_q == 3'd7) && pend_q;
    assign swap_ack  = swap_fire;
    assign wr_ptr    = {~disp_q, wr_addr};
    assign rd_base   = {disp_q, row_q, 3'b000};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            if (swap_fire) disp_q <= ~disp_q;
            pend_q <= swap_req | (pend_q & ~swap_fire);
        end
    end
`else
    logic unused_swap_req;

    assign unused_swap_req = swap_req;
    assign swap_ack        = 1'b0;
    assign wr_ptr          = wr_addr;
    assign rd_base         = {row_q, 3'b000};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_ptr] <= wr_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        blank_d    = blank_q;
        dwell_d    = dwell_q;
        row_d      = row_q;
        ocr_d      = ocr_q;
        drive_done = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (blank_q == 8'(BLANK_CYCLES - 1)) begin
                    blank_d = '0;
                    state_d = ST_LOAD;
                end else begin
                    blank_d = blank_q + 8'd1;
                end
            end
            ST_LOAD: begin
                // Snapshot the row here so later writes cannot disturb the row being driven.
                for (int c = 0; c < 8; c++) ocr_d[c] = mem_q[rd_base | AW'(c)];
                dwell_d = '0;
                state_d = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (dwell_q == DW'(DWELL_CLKS - 1)) begin
                    drive_done = 1'b1;
                    dwell_d    = '0;
                    row_d      = row_q + 3'd1;
                    state_d    = ST_BLANK;
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            default: state_d = ST_BLANK;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_BLANK;
            blank_q <= '0;
            dwell_q <= '0;
            row_q   <= '0;
            for (int c = 0; c < 8; c++) ocr_q[c] <= '0;
        end else begin
            state_q <= state_d;
            blank_q <= blank_d;
            dwell_q <= dwell_d;
            row_q   <= row_d;
            ocr_q   <= ocr_d;
        end
    end

    assign en          = (state_q == ST_DRIVE);
    assign row_n       = (state_q == ST_BLANK) ? 8'hFF : ~(8'd1 << row_q);
    assign frame_start = (state_q == ST_LOAD) && (row_q == 3'd0);

    assign ocr1 = ocr_q[0];
    assign ocr2 = ocr_q[1];
    assign ocr3 = ocr_q[2];
    assign ocr4 = ocr_q[3];
    assign ocr5 = ocr_q[4];
    assign ocr6 = ocr_q[5];
    assign ocr7 = ocr_q[6];
    assign ocr8 = ocr_q[7];

endmodule

// File: tb/tb_row_scan_controller.sv
// Scoreboard bench for row_scan_controller: stimulus queues one expected row per slot,
// a monitor pops and compares each time the DUT enters DRIVE.
module tb_row_scan_controller;

    localparam int BLANK = 8;
    localparam int DWELL = 256;
`ifdef DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic        swap_req = 1'b0;
    logic        swap_ack, en, frame_start;
    logic [7:0]  row_n;
    logic [23:0] ocr1, ocr2, ocr3, ocr4, ocr5, ocr6, ocr7, ocr8;
    logic [191:0] ocr_all;

    assign ocr_all = {ocr8, ocr7, ocr6, ocr5, ocr4, ocr3, ocr2, ocr1};

    row_scan_controller #(.DWELL_PERIODS(1), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .swap_req(swap_req), .swap_ack(swap_ack),
        .ocr1(ocr1), .ocr2(ocr2), .ocr3(ocr3), .ocr4(ocr4),
        .ocr5(ocr5), .ocr6(ocr6), .ocr7(ocr7), .ocr8(ocr8),
        .en(en), .row_n(row_n), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   row_n;
        logic [191:0] ocr;
        logic         fs;
        logic         ack;
    } exp_t;

    exp_t        q[$];
    logic [23:0] mdl [2][64];
    int          disp;
    bit          pend;
    int          n_chk = 0;
    int          n_pass = 0;

    function automatic void chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic void mdl_clear();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 64; i++) mdl[b][i] = '0;
        disp = 0;
        pend = 1'b0;
    endfunction

    function automatic bit push_row(input int r);
        exp_t e;
        e.row_n = ~(8'd1 << r);
        for (int c = 0; c < 8; c++) e.ocr[c*24 +: 24] = mdl[disp][r*8 + c];
        e.fs  = (r == 0);
        e.ack = (r == 7) && pend;
        q.push_back(e);
        return e.ack;
    endfunction

    task automatic wr(input logic [5:0] a, input logic [23:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk);
        mdl[DB ? 1 - disp : disp][a] = d;
        #1 wr_en = 1'b0;
    endtask

    task automatic pulse_swap();
        @(negedge clk);
        swap_req = 1'b1;
        @(posedge clk);
        if (DB) pend = 1'b1;
        #1 swap_req = 1'b0;
    endtask

    // One row slot, entered just after the edge that starts its BLANK phase.
    task automatic run_slot(input int r, input int act);
        bit ack;
        int used;
        ack = push_row(r);
        repeat (BLANK + 1) @(posedge clk);
        used = 0;
        case (act)
            0: begin
                wr(6'o23, 24'h0A0B0C); wr(6'o10, 24'h112233); wr(6'o77, 24'hABCDEF); used = 3;
            end
            1: begin wr(6'o15, 24'h55AA55); used = 1; end
            10: begin
                for (int a = 0; a < 64; a++) wr(6'(a), 24'hFFFFFF);
                used = 64;
            end
            11: begin pulse_swap(); used = 1; end
            default: ;
        endcase
        repeat (DWELL - used) @(posedge clk);
        if (ack) begin disp = 1 - disp; pend = 1'b0; end
        #1;
    endtask

    // Monitor: counts phase lengths and checks each row against the queue.
    int   blank_n, load_n, drive_n, bad_hold, ack_n;
    bit   prev_en, have_cur, fs_seen;
    exp_t cur;

    always @(negedge clk) begin
        if (reset) begin
            blank_n = 0; load_n = 0; drive_n = 0; bad_hold = 0; ack_n = 0;
            prev_en = 1'b0; have_cur = 1'b0; fs_seen = 1'b0;
        end else begin
            if (!en && row_n == 8'hFF) begin
                if (prev_en && have_cur) begin
                    chk("drive_len", drive_n, DWELL);
                    chk("drive_hold", bad_hold, 0);
                    chk("swap_ack", ack_n, cur.ack);
                    have_cur = 1'b0;
                end
                blank_n++;
            end else if (!en) begin
                load_n++;
                fs_seen = frame_start;
            end else begin
                if (!prev_en) begin
                    if (q.size() == 0) begin
                        chk("unexpected_row", 0, 1);
                    end else begin
                        cur = q.pop_front();
                        have_cur = 1'b1;
                        chk("row_n", row_n, cur.row_n);
                        chk("ocr", ocr_all, cur.ocr);
                        chk("frame_start", fs_seen, cur.fs);
                        chk("blank_len", blank_n, BLANK);
                        chk("load_len", load_n, 1);
                    end
                    blank_n = 0; load_n = 0; drive_n = 0; bad_hold = 0; ack_n = 0;
                end
                drive_n++;
                if (have_cur && (row_n !== cur.row_n || ocr_all !== cur.ocr)) bad_hold++;
                if (swap_ack) ack_n++;
            end
            prev_en = en;
        end
    end

    initial begin
        mdl_clear();
        #1 reset = 1'b1;
        #1;
        chk("rst_en", en, 0);
        chk("rst_row_n", row_n, 8'hFF);
        chk("rst_ocr", ocr_all, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_swap_ack", swap_ack, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Frames 0..2 up to row 5, which is aborted by reset mid-DRIVE.
        for (int s = 0; s < 21; s++) run_slot(s % 8, s);
        void'(push_row(5));
        repeat (BLANK + 1 + 100) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_en", en, 0);
        chk("mid_rst_row_n", row_n, 8'hFF);
        chk("mid_rst_ocr", ocr_all, 0);
        chk("mid_rst_frame_start", frame_start, 0);
        mdl_clear();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Restart must begin at row 0 with a fresh, empty store.
        run_slot(0, -1);
        run_slot(1, -1);
        repeat (5) @(posedge clk);
        chk("rows_outstanding", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
